// File: rtl/com_uart_trans_ctrl_if.sv
// TX FIFO read port between the UART transmit controller and its FIFO.
// The controller pops with FIFO_rd_en; data is valid the following clk.
interface com_uart_trans_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  FIFO_empty;
    logic [DATA_WIDTH-1:0] FIFO_data;
    logic                  FIFO_rd_en;

    modport master (
        input  FIFO_empty,
        input  FIFO_data,
        output FIFO_rd_en
    );

    modport slave (
        output FIFO_empty,
        output FIFO_data,
        input  FIFO_rd_en
    );
endinterface

// File: rtl/com_uart_trans_ctrl.sv
// UART transmit framing FSM: pops the TX FIFO and serialises
// start, LSB-first payload, optional parity and 1/2 stop bits.
module com_uart_trans_ctrl #(
    parameter int         DATA_WIDTH  = 8,
    parameter logic [1:0] PARITY_NONE = 2'd0,
    parameter logic [1:0] PARITY_ODD  = 2'd1,
    parameter logic [1:0] PARITY_EVEN = 2'd2
) (
    input  logic                         clk,
    input  logic                         rst,
    com_uart_trans_ctrl_if.master        fifo,
    input  logic                         baud_tick,
    input  logic [1:0]                   parity_mode,
    input  logic                         stop_bits_sel,
    output logic                         TX,
    output logic                         ctrl_idle_state,
    output logic                         ctrl_stop_state,
    output logic                         TX_done
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [1:0]            mode_q, mode_d;
    logic                  stop2_q, stop2_d;
    logic                  scnt_q, scnt_d;
    logic                  tx_q, tx_d;
    logic                  idle_q, idle_d;
    logic                  stp_q, stp_d;
    logic                  done_q, done_d;
    logic                  pop;
    logic                  has_par;
    logic                  par_bit;

    // Latched mode is normalised at LOAD, so encoding 3 already reads as none
    assign has_par = (mode_q != PARITY_NONE);
    assign par_bit = (^byte_q) ^ (mode_q == PARITY_ODD);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        stop2_d = stop2_q;
        scnt_d  = scnt_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo.FIFO_empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sr_d    = fifo.FIFO_data;
                byte_d  = fifo.FIFO_data;
                mode_d  = (parity_mode == PARITY_ODD ||
                           parity_mode == PARITY_EVEN) ?
                          parity_mode : PARITY_NONE;
                stop2_d = stop_bits_sel;
                idx_d   = '0;
                scnt_d  = 1'b0;
                state_d = START;
            end
            START: begin
                if (baud_tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    sr_d = sr_q >> 1;
                    if (idx_q == LAST)
                        state_d = has_par ? PARITY : STOP;
                    else
                        idx_d = idx_q + 1'b1;
                end
            end
            PARITY: begin
                if (baud_tick)
                    state_d = STOP;
            end
            STOP: begin
                if (baud_tick) begin
                    if (!stop2_q || scnt_q) begin
                        done_d = 1'b1;
                        if (!fifo.FIFO_empty) begin
                            pop     = 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        scnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs decode the next state so they line up with the state register
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sr_d[0];
            PARITY:  tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
        idle_d = (state_d == IDLE);
        stp_d  = (state_d == STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            mode_q  <= PARITY_NONE;
            stop2_q <= 1'b0;
            scnt_q  <= 1'b0;
            tx_q    <= 1'b1;
            idle_q  <= 1'b1;
            stp_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            stop2_q <= stop2_d;
            scnt_q  <= scnt_d;
            tx_q    <= tx_d;
            idle_q  <= idle_d;
            stp_q   <= stp_d;
            done_q  <= done_d;
        end
    end

    assign fifo.FIFO_rd_en  = pop & ~rst;
    assign TX               = tx_q;
    assign ctrl_idle_state  = idle_q;
    assign ctrl_stop_state  = stp_q;
    assign TX_done          = done_q;
endmodule

// File: tb/tb_com_uart_trans_ctrl.sv
// Bench for com_uart_trans_ctrl: FIFO model, frame-bit scoreboard,
// vector table plus back-to-back, config-change and reset sequences.
module tb_com_uart_trans_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [1:0] parity_mode;
    logic       stop_bits_sel;
    logic       TX;
    logic       ctrl_idle_state;
    logic       ctrl_stop_state;
    logic       TX_done;

    com_uart_trans_ctrl_if #(.DATA_WIDTH(8)) fifo_if ();

    com_uart_trans_ctrl #(.DATA_WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo            (fifo_if),
        .baud_tick       (baud_tick),
        .parity_mode     (parity_mode),
        .stop_bits_sel   (stop_bits_sel),
        .TX              (TX),
        .ctrl_idle_state (ctrl_idle_state),
        .ctrl_stop_state (ctrl_stop_state),
        .TX_done         (TX_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       ssel;
        logic       has_par;
        logic       par;
        int         len;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    bit         exp_q[$];
    logic [7:0] fq[$];
    int         done_cnt = 0;
    int         rd_cnt = 0;
    int         bits_seen = 0;
    int         b2b_rd = 0;
    bit         mon_en = 1'b0;
    bit         rd_prev = 1'b0;
    bit         mbit;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // FIFO model: pop on rd_en, data valid next clk
    always @(posedge clk) begin
        if (fifo_if.FIFO_rd_en && fq.size() > 0)
            fifo_if.FIFO_data <= fq.pop_front();
        #1 fifo_if.FIFO_empty = (fq.size() == 0);
    end

    // Monitor: sample TX on each tick the frame should consume
    always @(negedge clk) begin
        if (mon_en) begin
            if (TX_done) done_cnt++;
            if (fifo_if.FIFO_rd_en) begin
                rd_cnt++;
                chk("rd_en_when_empty", fifo_if.FIFO_empty, 0);
                if (baud_tick && ctrl_stop_state) b2b_rd++;
            end
            if (ctrl_stop_state)
                chk("idle_stop_excl", ctrl_idle_state, 0);
            if (baud_tick && !ctrl_idle_state && !rd_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    mbit = exp_q.pop_front();
                    chk("tx_bit", TX, mbit);
                end
                bits_seen++;
            end
        end
        rd_prev = fifo_if.FIFO_rd_en;
    end

    task automatic tick();
        @(posedge clk);
        #1 baud_tick = 1'b1;
        @(posedge clk);
        #1 baud_tick = 1'b0;
        @(posedge clk);
    endtask

    task automatic push_frame(logic [7:0] d, bit hp, bit p, bit s2);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (hp) exp_q.push_back(p);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endtask

    task automatic run_until_done(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("tx_done_count", done_cnt, target);
    endtask

    vec_t vt[9];

    initial begin
        int d0, r0, b0;
        vt[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 10};
        vt[1] = '{8'h03, 2'd2, 1'b0, 1'b1, 1'b0, 11};
        vt[2] = '{8'h03, 2'd1, 1'b0, 1'b1, 1'b1, 11};
        vt[3] = '{8'h55, 2'd0, 1'b1, 1'b0, 1'b0, 11};
        vt[4] = '{8'hFF, 2'd2, 1'b1, 1'b1, 1'b0, 12};
        vt[5] = '{8'h80, 2'd1, 1'b0, 1'b1, 1'b0, 11};
        vt[6] = '{8'h00, 2'd1, 1'b1, 1'b1, 1'b1, 12};
        vt[7] = '{8'hB6, 2'd3, 1'b0, 1'b0, 1'b0, 10};
        vt[8] = '{8'hC4, 2'd2, 1'b0, 1'b1, 1'b1, 11};

        rst = 1'b1;
        baud_tick = 1'b0;
        parity_mode = 2'd0;
        stop_bits_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", TX, 1);
        chk("rst_idle", ctrl_idle_state, 1);
        chk("rst_stop", ctrl_stop_state, 0);
        chk("rst_rd_en", fifo_if.FIFO_rd_en, 0);
        chk("rst_done", TX_done, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Ticks with an empty FIFO must be ignored
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("idle_tick_tx", TX, 1);
            chk("idle_tick_idle", ctrl_idle_state, 1);
            chk("idle_tick_rd", fifo_if.FIFO_rd_en, 0);
        end

        foreach (vt[k]) begin
            parity_mode = vt[k].pmode;
            stop_bits_sel = vt[k].ssel;
            d0 = done_cnt;
            r0 = rd_cnt;
            b0 = bits_seen;
            push_frame(vt[k].data, vt[k].has_par, vt[k].par, vt[k].ssel);
            fq.push_back(vt[k].data);
            run_until_done(d0 + 1, 40);
            chk("frame_len", bits_seen - b0, vt[k].len);
            chk("rd_en_count", rd_cnt - r0, 1);
            chk("sb_drained", exp_q.size(), 0);
            chk("back_idle", ctrl_idle_state, 1);
            chk("back_tx", TX, 1);
        end

        // Back-to-back frames, two stop bits
        parity_mode = 2'd0;
        stop_bits_sel = 1'b1;
        d0 = done_cnt;
        r0 = rd_cnt;
        b0 = b2b_rd;
        push_frame(8'h55, 1'b0, 1'b0, 1'b1);
        push_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        fq.push_back(8'h55);
        fq.push_back(8'hFF);
        for (int n = 0; n < 40 && done_cnt < d0 + 1; n++) tick();
        #1;
        chk("b2b_no_idle", ctrl_idle_state, 0);
        run_until_done(d0 + 2, 40);
        chk("b2b_rd_count", rd_cnt - r0, 2);
        chk("b2b_rd_on_stop", b2b_rd - b0, 1);
        chk("b2b_sb_drained", exp_q.size(), 0);

        // Config changes mid-frame must not affect it
        parity_mode = 2'd2;
        stop_bits_sel = 1'b0;
        d0 = done_cnt;
        b0 = bits_seen;
        push_frame(8'h03, 1'b1, 1'b0, 1'b0);
        fq.push_back(8'h03);
        repeat (6) tick();
        parity_mode = 2'd1;
        stop_bits_sel = 1'b1;
        run_until_done(d0 + 1, 40);
        chk("cfg_frame_len", bits_seen - b0, 11);
        chk("cfg_sb_drained", exp_q.size(), 0);

        // Reset in the middle of DATA bit 4
        parity_mode = 2'd0;
        stop_bits_sel = 1'b0;
        b0 = bits_seen;
        push_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        fq.push_back(8'hA5);
        for (int n = 0; n < 20 && bits_seen - b0 < 5; n++) tick();
        chk("pre_rst_bits", bits_seen - b0, 5);
        mon_en = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        r0 = rd_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx", TX, 1);
        chk("midrst_idle", ctrl_idle_state, 1);
        chk("midrst_done", TX_done, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) tick();
        chk("midrst_no_done", done_cnt, d0);
        chk("midrst_no_rd", rd_cnt, r0);

        parity_mode = 2'd1;
        b0 = bits_seen;
        push_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        fq.push_back(8'h3C);
        run_until_done(d0 + 1, 40);
        chk("post_rst_len", bits_seen - b0, 11);
        chk("post_rst_sb", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/com_uart_trans_ctrl.md
COM_UART_TRANS_CTRL -- requirements
Module: com_uart_trans_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of payload bits per frame.
REQ-002 Parameter PARITY_NONE/PARITY_ODD/PARITY_EVEN, default 0/1/2: parity_mode encodings.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 baud_tick  input  1  one-clk pulse per bit period from the transmit timer.
REQ-006 FIFO_empty  input  1  TX FIFO empty flag.
REQ-007 FIFO_data  input  DATA_WIDTH  FIFO read data, valid the clk after FIFO_rd_en.
REQ-008 parity_mode  input  2  parity select (none/odd/even); encoding 3 SHALL behave as none.
REQ-009 stop_bits_sel  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 FIFO_rd_en  output  1  one-clk FIFO pop request.
REQ-011 TX  output  1  serial line, idle high, registered.
REQ-012 ctrl_idle_state  output  1  high while in IDLE.
REQ-013 ctrl_stop_state  output  1  high while in STOP.
REQ-014 TX_done  output  1  one-clk pulse at end of each frame's final stop bit.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, START, DATA, PARITY, STOP.
REQ-016 IDLE: if FIFO_empty=0, assert FIFO_rd_en for exactly that clk and go to LOAD; else stay, TX=1.
REQ-017 LOAD: latch FIFO_data into shift register, latch parity_mode and stop_bits_sel, go to START; TX stays 1; duration exactly one clk.
REQ-018 Config inputs changing after LOAD SHALL NOT affect the frame in progress.
REQ-019 START: TX=0 from the clk after entry; on baud_tick go to DATA with bit index 0.
REQ-020 DATA: TX = shift register bit 0 (LSB first); on baud_tick shift right, increment index; after bit DATA_WIDTH-1 go to PARITY if latched mode is odd/even, else STOP.
REQ-021 Parity bit: even = XOR of latched payload; odd = inverse of that XOR; computed from the latched byte, not the shifting register.
REQ-022 PARITY: TX = parity bit; on baud_tick go to STOP.
REQ-023 STOP: TX=1; counts baud_ticks; exits on 1st tick (stop_bits_sel=0) or 2nd tick (stop_bits_sel=1).
REQ-024 On STOP exit: pulse TX_done; if FIFO_empty=0 assert FIFO_rd_en same clk and go to LOAD (back-to-back, no idle gap beyond LOAD); else go to IDLE.
REQ-025 baud_tick in IDLE or LOAD SHALL be ignored.
REQ-026 baud_tick held high for multiple clks SHALL advance exactly one bit per clk it is high (no edge detection); timer guarantees single-cycle pulses.
REQ-027 FIFO_rd_en SHALL never assert when FIFO_empty=1.
REQ-028 Bit index counter width SHALL be $clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1.
REQ-029 ctrl_idle_state and ctrl_stop_state SHALL be registered decodes of the current state, mutually exclusive.
REQ-030 Frame length SHALL be 1 + DATA_WIDTH + (parity?1:0) + (1 or 2) baud_ticks after START entry.

Reset
REQ-031 rst=1 at a clk edge SHALL force IDLE regardless of state, including mid-frame.
REQ-032 Reset values: TX=1, ctrl_idle_state=1, ctrl_stop_state=0, FIFO_rd_en=0, TX_done=0, shift register=0, counters=0.
REQ-033 A frame interrupted by reset SHALL be abandoned; the popped byte is lost, no TX_done.

Verification
REQ-034 FIFO holds 0xA5, parity none, 1 stop -> TX sequence 0,1,0,1,0,0,1,0,1,1 one bit per tick; one FIFO_rd_en; TX_done after 10th tick; return to IDLE.
REQ-035 0x03 with even parity -> parity bit 0; odd parity -> parity bit 1; frame 11 ticks.
REQ-036 Two bytes 0x55,0xFF queued, 2 stop bits -> second FIFO_rd_en on the clk of 2nd stop tick; LOAD then START with no IDLE; ctrl_idle_state stays 0.
REQ-037 Change parity_mode and stop_bits_sel during DATA -> frame uses values latched at LOAD.
REQ-038 Assert rst during DATA bit 4 -> next clk TX=1, ctrl_idle_state=1, no TX_done; next frame starts cleanly.
REQ-039 baud_tick pulses while FIFO_empty=1 in IDLE -> no state change, FIFO_rd_en stays 0, TX=1.
